vec_byte_mem_port: RTL and testbench

//  - Memory-side responder for the vector pipeline's MEM stage: serves one R-lane vector LD/ST per request.
//  - Talks to a byte-wide synchronous data memory, one byte per cycle.
//  - Store: unpacks the R x N-bit WriteDataM into R byte writes.
//  - Load: issues R byte reads and packs the results into ReadDataM for segment_mem_wb.
//  - Holds the pipeline with MemBusy while a transfer is in progress.

---
 rtl/vec_byte_mem_port.sv | 121 ++++++++++++
 tb/tb_vec_byte_mem_port.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/vec_byte_mem_port.sv
// vec_byte_mem_port: serves one R-lane vector load/store per request over a
// byte-wide synchronous memory, one byte per cycle, stalling the pipeline meanwhile.
`default_nettype none

module vec_byte_mem_port #(
  parameter int I = 32,
  parameter int N = 8,
  parameter int R = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                MemReqM,
  input  logic                MemWriteM,
  input  logic [I-1:0]        AddressM,
  input  logic [R-1:0][N-1:0] WriteDataM,
  output logic [R-1:0][N-1:0] ReadDataM,
  output logic                MemBusy,
  output logic                MemDone,
  output logic [I-1:0]        bmem_addr,
  output logic                bmem_we,
  output logic [N-1:0]        bmem_wd,
  input  logic [N-1:0]        bmem_rd
);

  localparam int CW = (R > 1) ? $clog2(R) : 1;
  localparam logic [CW-1:0] LAST = CW'(R - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    STORE = 3'd1,
    LOAD  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [I-1:0]        base;
  logic [R-1:0][N-1:0] wdata;
  logic [R-1:0][N-1:0] shadow;

  logic [CW-1:0] cnt_nxt;
  logic [CW-1:0] cnt_prv;
  assign cnt_nxt = cnt + 1'b1;
  assign cnt_prv = cnt - 1'b1;

  // Stall is combinational so the accept cycle itself already holds the pipeline.
  assign MemBusy = !reset && (((state == IDLE) && MemReqM) ||
                              (state == STORE) || (state == LOAD) || (state == DRAIN));

  // Memory-side outputs are registered one step ahead: the value driven during a
  // STORE/LOAD cycle for lane cnt is set up at the edge entering that cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      base      <= '0;
      wdata     <= '0;
      shadow    <= '0;
      ReadDataM <= '0;
      MemDone   <= 1'b0;
      bmem_addr <= '0;
      bmem_we   <= 1'b0;
      bmem_wd   <= '0;
    end else begin
      case (state)
        IDLE: begin
          MemDone <= 1'b0;
          if (MemReqM) begin
            base      <= AddressM;
            wdata     <= WriteDataM;
            cnt       <= '0;
            bmem_addr <= AddressM;
            bmem_wd   <= WriteDataM[0];
            bmem_we   <= MemWriteM;
            state     <= MemWriteM ? STORE : LOAD;
          end
        end
        STORE: begin
          cnt <= cnt_nxt;
          if (cnt == LAST) begin
            bmem_we <= 1'b0;
            MemDone <= 1'b1;
            state   <= DONE;
          end else begin
            bmem_addr <= base + I'(cnt_nxt);
            bmem_wd   <= wdata[cnt_nxt];
          end
        end
        LOAD: begin
          cnt <= cnt_nxt;
          // Read data lags the address by one cycle, so lane cnt-1 arrives now.
          if (cnt != '0) shadow[cnt_prv] <= bmem_rd;
          if (cnt == LAST) begin
            state <= DRAIN;
          end else begin
            bmem_addr <= base + I'(cnt_nxt);
          end
        end
        DRAIN: begin
          ReadDataM <= {bmem_rd, shadow[R-2:0]};
          MemDone   <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          MemDone <= 1'b0;
          bmem_we <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          MemDone <= 1'b0;
          bmem_we <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vec_byte_mem_port.sv
// tb_vec_byte_mem_port: directed vectors against a byte-memory model with a write log.
`default_nettype none

module tb_vec_byte_mem_port;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemReqM = 1'b0;
  logic        MemWriteM = 1'b0;
  logic [31:0] AddressM = '0;
  logic [47:0] WriteDataM = '0;
  logic [47:0] ReadDataM;
  logic        MemBusy;
  logic        MemDone;
  logic [31:0] bmem_addr;
  logic        bmem_we;
  logic [7:0]  bmem_wd;
  logic [7:0]  bmem_rd = '0;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t        wlog[$];
  logic [7:0] mem[logic [31:0]];

  vec_byte_mem_port #(.I(32), .N(8), .R(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemReqM    (MemReqM),
    .MemWriteM  (MemWriteM),
    .AddressM   (AddressM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .MemBusy    (MemBusy),
    .MemDone    (MemDone),
    .bmem_addr  (bmem_addr),
    .bmem_we    (bmem_we),
    .bmem_wd    (bmem_wd),
    .bmem_rd    (bmem_rd)
  );

  always #5 clk = ~clk;

  // Synchronous-read byte memory; every write is also logged in order.
  always @(posedge clk) begin
    bmem_rd <= mem.exists(bmem_addr) ? mem[bmem_addr] : 8'h00;
    if (bmem_we) begin
      mem[bmem_addr] = bmem_wd;
      wlog.push_back('{a: bmem_addr, d: bmem_wd});
    end
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one transfer from its accept cycle to its MemDone cycle (sampled at negedge).
  task automatic run_xfer(input logic we, input logic [31:0] addr, input logic [47:0] data,
                          input bit hold_req, input bit intrude,
                          output int busy, output int done_at);
    @(negedge clk);
    MemReqM = 1'b1; MemWriteM = we; AddressM = addr; WriteDataM = data;
    busy = 0; done_at = -1;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (MemBusy) busy++;
      if (MemDone) begin
        done_at = c;
        break;
      end
      if (c == 1 && !hold_req) MemReqM = 1'b0;
      if (intrude && c == 3) begin
        MemReqM = 1'b1; AddressM = addr ^ 32'h100; WriteDataM = ~data;
      end
      if (intrude && c == 4) MemReqM = 1'b0;
    end
    if (done_at < 0) check_val("xfer_timeout", 64'd0, 64'd1);
  endtask

  task automatic check_wlog(input string tag, input logic [31:0] base, input logic [47:0] data);
    logic [47:0] d;
    d = data;
    check_val({tag, "_nwr"}, 64'(wlog.size()), 64'd6);
    for (int k = 0; k < 6 && k < wlog.size(); k++) begin
      check_val($sformatf("%s_addr%0d", tag, k), 64'(wlog[k].a), 64'(32'(base + 32'(k))));
      check_val($sformatf("%s_data%0d", tag, k), 64'(wlog[k].d), 64'(d[8*k +: 8]));
    end
  endtask

  int busy, done_at;

  initial begin
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_rdata", 64'(ReadDataM), 64'd0);
    check_val("rst_busy",  64'(MemBusy),   64'd0);
    check_val("rst_done",  64'(MemDone),   64'd0);
    check_val("rst_addr",  64'(bmem_addr), 64'd0);
    check_val("rst_we",    64'(bmem_we),   64'd0);
    check_val("rst_wd",    64'(bmem_wd),   64'd0);
    reset = 1'b0;

    // Basic store then load back.
    wlog.delete();
    run_xfer(1'b1, 32'h0000_0010, 48'h0605_0403_0201, 1'b0, 1'b0, busy, done_at);
    check_val("st_busy", 64'(busy), 64'd7);
    check_val("st_done_at", 64'(done_at), 64'd7);
    check_wlog("st", 32'h0000_0010, 48'h0605_0403_0201);
    @(negedge clk); #1;
    check_val("st_done_pulse", 64'(MemDone), 64'd0);
    check_val("st_we_idle", 64'(bmem_we), 64'd0);

    run_xfer(1'b0, 32'h0000_0010, 48'h0, 1'b0, 1'b0, busy, done_at);
    check_val("ld_busy", 64'(busy), 64'd8);
    check_val("ld_done_at", 64'(done_at), 64'd8);
    check_val("ld_rdata", 64'(ReadDataM), 64'h0605_0403_0201);

    // Address wrap at the top of the address space.
    wlog.delete();
    run_xfer(1'b1, 32'hFFFF_FFFE, 48'h3635_3433_3231, 1'b0, 1'b0, busy, done_at);
    check_wlog("wrap", 32'hFFFF_FFFE, 48'h3635_3433_3231);
    if (wlog.size() > 2) check_val("wrap_zero", 64'(wlog[2].a), 64'd0);
    check_val("wrap_rdata_kept", 64'(ReadDataM), 64'h0605_0403_0201);

    // Back-to-back store then load with MemReqM held through DONE.
    wlog.delete();
    run_xfer(1'b1, 32'h0000_0040, 48'hC5B4_A392_8170, 1'b1, 1'b0, busy, done_at);
    check_val("b2b_st_done_at", 64'(done_at), 64'd7);
    run_xfer(1'b0, 32'h0000_0040, 48'h0, 1'b0, 1'b0, busy, done_at);
    check_val("b2b_ld_busy", 64'(busy), 64'd8);
    check_val("b2b_ld_done_at", 64'(done_at), 64'd8);
    check_val("b2b_rdata", 64'(ReadDataM), 64'hC5B4_A392_8170);
    check_wlog("b2b", 32'h0000_0040, 48'hC5B4_A392_8170);

    // Foreign request mid-store must be ignored.
    wlog.delete();
    run_xfer(1'b1, 32'h0000_0080, 48'h0F0E_0D0C_0B0A, 1'b0, 1'b1, busy, done_at);
    check_val("intr_done_at", 64'(done_at), 64'd7);
    check_wlog("intr", 32'h0000_0080, 48'h0F0E_0D0C_0B0A);
    check_val("intr_no_stray", 64'(mem.exists(32'h0000_0180)), 64'd0);
    check_val("intr_rdata_kept", 64'(ReadDataM), 64'hC5B4_A392_8170);

    // Reset in the middle of a load (cnt=3).
    @(negedge clk);
    MemReqM = 1'b1; MemWriteM = 1'b0; AddressM = 32'h0000_0010;
    @(negedge clk);
    MemReqM = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_val("mid_busy", 64'(MemBusy), 64'd1);
    check_val("mid_rdata_hidden", 64'(ReadDataM), 64'hC5B4_A392_8170);
    reset = 1'b1;
    #1;
    check_val("rst_mid_we", 64'(bmem_we), 64'd0);
    check_val("rst_mid_busy", 64'(MemBusy), 64'd0);
    check_val("rst_mid_rdata", 64'(ReadDataM), 64'd0);
    check_val("rst_mid_addr", 64'(bmem_addr), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    run_xfer(1'b0, 32'h0000_0010, 48'h0, 1'b0, 1'b0, busy, done_at);
    check_val("post_rst_busy", 64'(busy), 64'd8);
    check_val("post_rst_rdata", 64'(ReadDataM), 64'h0605_0403_0201);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
